// File: rtl/retire_mon_pkg.sv
// Shared types for the pipeline retirement monitor: FSM state encoding and trace entry layout.
package retire_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_e;

  // Trace entry at the core's native 32-bit width; the buffer stores {pc, wb} in this order.
  localparam int unsigned TRACE_XLEN_DEF = 32;

  typedef struct packed {
    logic [TRACE_XLEN_DEF-1:0] pc;
    logic [TRACE_XLEN_DEF-1:0] wb;
  } trace_entry_t;

endpackage

// File: rtl/retire_trace_buf.sv
// Circular trace of the last DEPTH commits, read back newest-relative with a registered port.
module retire_trace_buf
  import retire_mon_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_clr,
  input  logic                     i_wr_en,
  input  logic [XLEN-1:0]          i_wr_pc,
  input  logic [XLEN-1:0]          i_wr_wb,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [XLEN-1:0]          o_rd_pc,
  output logic [XLEN-1:0]          o_rd_wb,
  output logic                     o_rd_vld
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = IDX_W + 1;

  logic [2*XLEN-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  rd_addr;
  logic [FILL_W-1:0] fill;
  logic              rd_hit;
  logic              wr_go;

  assign wr_go   = i_wr_en && !i_clr;
  // Index 0 is the entry just behind the write pointer; reads see pre-write contents.
  assign rd_addr = wr_ptr - IDX_W'(1) - i_rd_idx;
  assign rd_hit  = {1'b0, i_rd_idx} < fill;

  always_ff @(posedge i_clk) begin
    if (wr_go) mem[wr_ptr] <= {i_wr_pc, i_wr_wb};
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      wr_ptr   <= '0;
      fill     <= '0;
      o_rd_pc  <= '0;
      o_rd_wb  <= '0;
      o_rd_vld <= 1'b0;
    end else begin
      if (wr_go) begin
        wr_ptr <= wr_ptr + IDX_W'(1);
        if (fill != FILL_W'(DEPTH)) fill <= fill + FILL_W'(1);
      end
      o_rd_vld <= rd_hit;
      if (rd_hit) {o_rd_pc, o_rd_wb} <= mem[rd_addr];
      else        {o_rd_pc, o_rd_wb} <= '0;
    end
  end

endmodule

// File: rtl/pipeline_retire_monitor.sv
// Retirement monitor: counters, halt/stall detection FSM and optional commit trace.
// Trace buffer and read port are built only when RETIRE_MON_TRACE_EN is defined.
module pipeline_retire_monitor
  import retire_mon_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TRACE_DEPTH = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned HALT_REPEAT = 4,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_enable,
  input  logic                           i_clear,
  input  logic                           i_insn_vld,
  input  logic [XLEN-1:0]                i_pc,
  input  logic [XLEN-1:0]                i_wb_data,
  input  logic [$clog2(TRACE_DEPTH)-1:0] i_rd_idx,
  output logic [XLEN-1:0]                o_rd_pc,
  output logic [XLEN-1:0]                o_rd_wb,
  output logic                           o_rd_vld,
  output logic [CNT_W-1:0]               o_retired,
  output logic [CNT_W-1:0]               o_cycles,
  output logic [1:0]                     o_state,
  output logic                           o_halted,
  output logic                           o_timeout
);

  localparam int unsigned RPT_W  = $clog2(HALT_REPEAT + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  mon_state_e        state;
  logic [XLEN-1:0]   last_pc;
  logic [RPT_W-1:0]  rpt_cnt;
  logic [RPT_W-1:0]  rpt_next;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_next;
  logic              clr;
  logic              commit;
  logic              halt_hit;
  logic              timeout_hit;

  assign clr    = !i_rst_n || i_clear;
  assign commit = (state == ST_RUN) && i_insn_vld;

  // last_pc clears to 0 with rpt_cnt 0, so a first commit at PC 0 still yields a count of 1.
  always_comb begin
    rpt_next = RPT_W'(1);
    if (i_pc == last_pc) rpt_next = rpt_cnt + RPT_W'(1);
  end

  assign idle_next   = i_insn_vld ? '0 : idle_cnt + IDLE_W'(1);
  assign halt_hit    = commit && (rpt_next == RPT_W'(HALT_REPEAT));
  assign timeout_hit = (state == ST_RUN) && (idle_next == IDLE_W'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      o_retired <= '0;
      o_cycles  <= '0;
      o_halted  <= 1'b0;
      o_timeout <= 1'b0;
      last_pc   <= '0;
      rpt_cnt   <= '0;
      idle_cnt  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (i_enable) state <= ST_RUN;
        ST_RUN: begin
          if (o_cycles != '1) o_cycles <= o_cycles + CNT_W'(1);
          if (i_insn_vld) begin
            if (o_retired != '1) o_retired <= o_retired + CNT_W'(1);
            last_pc <= i_pc;
            rpt_cnt <= rpt_next;
          end
          idle_cnt <= idle_next;
          if (halt_hit) begin
            state    <= ST_HALTED;
            o_halted <= 1'b1;
          end else if (timeout_hit) begin
            state     <= ST_TIMEOUT;
            o_timeout <= 1'b1;
          end else if (!i_enable) begin
            state    <= ST_IDLE;
            idle_cnt <= '0;
          end
        end
        ST_HALTED:  ;
        ST_TIMEOUT: ;
      endcase
    end
  end

  assign o_state = state;

`ifdef RETIRE_MON_TRACE_EN
  retire_trace_buf #(
    .XLEN  (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .i_clk    (i_clk),
    .i_clr    (clr),
    .i_wr_en  (commit),
    .i_wr_pc  (i_pc),
    .i_wr_wb  (i_wb_data),
    .i_rd_idx (i_rd_idx),
    .o_rd_pc  (o_rd_pc),
    .o_rd_wb  (o_rd_wb),
    .o_rd_vld (o_rd_vld)
  );
`else
  logic unused_trace_inputs;
  assign unused_trace_inputs = ^{i_wb_data, i_rd_idx};
  assign o_rd_pc  = '0;
  assign o_rd_wb  = '0;
  assign o_rd_vld = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_retire_monitor.sv
// Self-checking bench for pipeline_retire_monitor (TRACE_DEPTH=4, HALT_REPEAT=4, TIMEOUT=8).
module tb_pipeline_retire_monitor;
  import retire_mon_pkg::*;

  typedef struct {
    string       name;
    bit          rst_n, en, clr, vld;
    logic [31:0] pc, wb;
    logic [1:0]  idx;
    logic [1:0]  e_state;
    logic [31:0] e_ret, e_cyc;
    bit          e_halt, e_to;
    bit          rd_chk, e_rd_vld;
    logic [31:0] e_rd_pc, e_rd_wb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, enable = 1'b0, clear = 1'b0, insn_vld = 1'b0;
  logic [31:0] pc = '0, wb_data = '0;
  logic [1:0]  rd_idx = '0;
  logic [31:0] rd_pc, rd_wb, retired, cycles;
  logic        rd_vld, halted, timeout;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  vec_t exp_q[$];
  vec_t tbl[13];

  localparam logic [1:0] I = ST_IDLE, R = ST_RUN, H = ST_HALTED, T = ST_TIMEOUT;

  pipeline_retire_monitor #(
    .XLEN(32), .TRACE_DEPTH(4), .CNT_W(32), .HALT_REPEAT(4), .TIMEOUT(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_clear(clear),
    .i_insn_vld(insn_vld), .i_pc(pc), .i_wb_data(wb_data), .i_rd_idx(rd_idx),
    .o_rd_pc(rd_pc), .o_rd_wb(rd_wb), .o_rd_vld(rd_vld),
    .o_retired(retired), .o_cycles(cycles), .o_state(state),
    .o_halted(halted), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input string name, input bit rst_n_i, en, clr, vld,
                              input logic [31:0] pc_i, wb_i, input logic [1:0] idx,
                              input logic [1:0] st, input logic [31:0] ret, cyc,
                              input bit h, t, rdc, rv, input logic [31:0] rpc, rwb);
    vec_t v;
    v.name = name; v.rst_n = rst_n_i; v.en = en; v.clr = clr; v.vld = vld;
    v.pc = pc_i; v.wb = wb_i; v.idx = idx; v.e_state = st; v.e_ret = ret; v.e_cyc = cyc;
    v.e_halt = h; v.e_to = t; v.rd_chk = rdc; v.e_rd_vld = rv; v.e_rd_pc = rpc; v.e_rd_wb = rwb;
    return v;
  endfunction

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %h expected %h", tag, fld, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst_n = v.rst_n; enable = v.en; clear = v.clr; insn_vld = v.vld;
    pc = v.pc; wb_data = v.wb; rd_idx = v.idx;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(e.name, "state",   32'(state),   32'(e.e_state));
    chk(e.name, "retired", retired,      e.e_ret);
    chk(e.name, "cycles",  cycles,       e.e_cyc);
    chk(e.name, "halted",  32'(halted),  32'(e.e_halt));
    chk(e.name, "timeout", 32'(timeout), 32'(e.e_to));
`ifdef RETIRE_MON_TRACE_EN
    if (e.rd_chk) begin
      chk(e.name, "rd_vld", 32'(rd_vld), 32'(e.e_rd_vld));
      if (e.e_rd_vld) begin
        chk(e.name, "rd_pc", rd_pc, e.e_rd_pc);
        chk(e.name, "rd_wb", rd_wb, e.e_rd_wb);
      end
    end
`else
    chk(e.name, "rd_vld_off", 32'(rd_vld), 32'd0);
    chk(e.name, "rd_pc_off",  rd_pc,       32'd0);
    chk(e.name, "rd_wb_off",  rd_wb,       32'd0);
`endif
  endtask

  initial begin
    // name, rst_n,en,clr,vld, pc,wb,idx, state,ret,cyc, halt,to, rd_chk,rd_vld,rd_pc,rd_wb
    tbl[0]  = mk("rst_a",    0,0,0,1, 32'h0,   32'h0,    0, I,0,0, 0,0, 1,0,0,0);
    tbl[1]  = mk("rst_b",    0,0,0,0, 32'h0,   32'h0,    0, I,0,0, 0,0, 1,0,0,0);
    tbl[2]  = mk("rst_c",    0,1,0,1, 32'h0,   32'h0,    0, I,0,0, 0,0, 1,0,0,0);
    tbl[3]  = mk("enter_run",1,1,0,0, 32'h0,   32'h0,    0, R,0,0, 0,0, 1,0,0,0);
    tbl[4]  = mk("ret_0",    1,1,0,1, 32'h0,   32'h1000, 0, R,1,1, 0,0, 1,0,0,0);
    tbl[5]  = mk("ret_4",    1,1,0,1, 32'h4,   32'h1004, 0, R,2,2, 0,0, 1,1,32'h0,32'h1000);
    tbl[6]  = mk("ret_8_rd0",1,1,0,1, 32'h8,   32'h1008, 0, R,3,3, 0,0, 1,1,32'h4,32'h1004);
    tbl[7]  = mk("rd_idx2",  1,1,0,0, 32'h0,   32'h0,    2, R,3,4, 0,0, 1,1,32'h0,32'h1000);
    tbl[8]  = mk("rd_idx0",  1,1,0,0, 32'h0,   32'h0,    0, R,3,5, 0,0, 1,1,32'h8,32'h1008);
    tbl[9]  = mk("rd_unfill",1,1,0,0, 32'h0,   32'h0,    3, R,3,6, 0,0, 1,0,0,0);
    tbl[10] = mk("en_drop",  1,0,0,0, 32'h0,   32'h0,    0, I,3,7, 0,0, 1,1,32'h8,32'h1008);
    tbl[11] = mk("idle_hold",1,0,0,1, 32'h100, 32'h1100, 0, I,3,7, 0,0, 1,1,32'h8,32'h1008);
    tbl[12] = mk("clear_1",  1,0,1,0, 32'h0,   32'h0,    0, I,0,0, 0,0, 1,0,0,0);
    foreach (tbl[i]) step(tbl[i]);

    // Halt: one PC change, then four retirements at 0x14 separated by idle cycles
    step(mk("h_en",   1,1,0,0, 32'h0,  32'h0,  0, R,0,0, 0,0, 0,0,0,0));
    step(mk("h_c10",  1,1,0,1, 32'h10, 32'h21, 0, R,1,1, 0,0, 0,0,0,0));
    step(mk("h_gap1", 1,1,0,0, 32'h0,  32'h0,  0, R,1,2, 0,0, 0,0,0,0));
    step(mk("h_c14a", 1,1,0,1, 32'h14, 32'h22, 0, R,2,3, 0,0, 0,0,0,0));
    step(mk("h_gap2", 1,1,0,0, 32'h0,  32'h0,  0, R,2,4, 0,0, 0,0,0,0));
    step(mk("h_c14b", 1,1,0,1, 32'h14, 32'h23, 0, R,3,5, 0,0, 0,0,0,0));
    step(mk("h_gap3", 1,1,0,0, 32'h0,  32'h0,  0, R,3,6, 0,0, 0,0,0,0));
    step(mk("h_c14c", 1,1,0,1, 32'h14, 32'h24, 0, R,4,7, 0,0, 0,0,0,0));
    step(mk("h_gap4", 1,1,0,0, 32'h0,  32'h0,  0, R,4,8, 0,0, 0,0,0,0));
    step(mk("h_c14d", 1,1,0,1, 32'h14, 32'h25, 0, H,5,9, 1,0, 0,0,0,0));
    step(mk("h_frozen",1,1,0,1,32'h18, 32'h26, 0, H,5,9, 1,0, 1,1,32'h14,32'h25));
    step(mk("h_en_off",1,0,0,0,32'h0,  32'h0,  3, H,5,9, 1,0, 1,1,32'h14,32'h22));
    step(mk("h_clear", 1,0,1,0,32'h0,  32'h0,  0, I,0,0, 0,0, 1,0,0,0));

    // Timeout: one commit, then exactly TIMEOUT idle cycles
    step(mk("t_en",   1,1,0,0, 32'h0,  32'h0,  0, R,0,0, 0,0, 0,0,0,0));
    step(mk("t_c40",  1,1,0,1, 32'h40, 32'h40, 0, R,1,1, 0,0, 0,0,0,0));
    for (int k = 1; k <= 7; k++)
      step(mk("t_idle", 1,1,0,0, 32'h0, 32'h0, 0, R,1,32'(1+k), 0,0, 0,0,0,0));
    step(mk("t_fire", 1,1,0,0, 32'h0,  32'h0,  0, T,1,9, 0,1, 0,0,0,0));
    step(mk("t_frozen",1,1,0,1,32'h44, 32'h44, 0, T,1,9, 0,1, 0,0,0,0));
    step(mk("t_clear",1,1,1,0, 32'h0,  32'h0,  0, I,0,0, 0,0, 0,0,0,0));

    // Trace wrap: seven back-to-back commits into a 4-deep trace
    step(mk("w_en",   1,1,0,0, 32'h0,  32'h0,  0, R,0,0, 0,0, 0,0,0,0));
    for (int k = 0; k < 7; k++)
      step(mk("w_commit", 1,1,0,1, 32'(4*k), 32'(32'h300+k), 0, R,32'(k+1),32'(k+1), 0,0, 0,0,0,0));
    for (int i = 0; i < 4; i++)
      step(mk("w_read", 1,1,0,0, 32'h0, 32'h0, 2'(i), R,7,32'(8+i), 0,0, 1,1,32'(32'h18-4*i),32'(32'h306-i)));
    step(mk("w_en_off",1,0,0,0,32'h0,  32'h0,  0, I,7,12, 0,0, 1,1,32'h18,32'h306));
    step(mk("w_clear",1,0,1,0, 32'h0,  32'h0,  0, I,0,0, 0,0, 1,0,0,0));
    step(mk("w_empty",1,0,0,0, 32'h0,  32'h0,  0, I,0,0, 0,0, 1,0,0,0));

    // Clear and reset colliding with commits
    step(mk("s_en",   1,1,0,0, 32'h0,  32'h0,  0, R,0,0, 0,0, 0,0,0,0));
    step(mk("s_clr_vld",1,1,1,1,32'h50,32'h50, 0, I,0,0, 0,0, 1,0,0,0));
    step(mk("s_reen", 1,1,0,0, 32'h0,  32'h0,  0, R,0,0, 0,0, 1,0,0,0));
    step(mk("s_c54",  1,1,0,1, 32'h54, 32'h54, 0, R,1,1, 0,0, 1,0,0,0));
    step(mk("s_rst_vld",0,1,0,1,32'h58,32'h58, 0, I,0,0, 0,0, 1,0,0,0));
    step(mk("s_after",1,0,0,0, 32'h0,  32'h0,  0, I,0,0, 0,0, 1,0,0,0));

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard: %0d expected records left unchecked", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_retire_monitor.md
# pipeline_retire_monitor

Parametrised retirement monitor for the 5-stage pipeline, attached to the core's commit outputs (`o_insn_vld`, `o_pc_debug`, `o_wb_data`). It counts retired instructions and active cycles, detects a program halt (a self-loop at one PC) and a retirement stall (timeout), and keeps a circular trace of the last `TRACE_DEPTH` commits that can be read back by index. It replaces fixed-delay `$stop` scheduling in benches and serves as an on-chip debug probe.

## Interface
- `XLEN`, 32, PC and writeback data width
- `TRACE_DEPTH`, 16, number of trace entries; power of two, ≥2
- `CNT_W`, 32, width of the retire and cycle counters
- `HALT_REPEAT`, 4, number of consecutive retirements at the same PC that declares a halt; ≥2
- `TIMEOUT`, 1024, number of consecutive RUN cycles without a retirement that declares a stall; ≥1
- `i_clk` in 1: clock
- `i_rst_n` in 1: **reset, synchronous and active-low, on the single clock `i_clk`**
- `i_enable` in 1: monitoring enabled
- `i_clear` in 1: clears counters, trace and sticky flags; returns FSM to IDLE
- `i_insn_vld` in 1: a commit happens this cycle
- `i_pc` in XLEN: PC of the committing instruction
- `i_wb_data` in XLEN: writeback data of the committing instruction
- `i_rd_idx` in $clog2(TRACE_DEPTH): trace read index; 0 = most recent entry
- `o_rd_pc`, `o_rd_wb` out XLEN: trace read data
- `o_rd_vld` out 1: the read index refers to a filled entry
- `o_retired` out CNT_W: retired-instruction count
- `o_cycles` out CNT_W: number of cycles spent in RUN
- `o_state` out 2: 0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT
- `o_halted`, `o_timeout` out 1: sticky status flags

## Operation
- States and transitions:
  - IDLE → RUN when `i_enable`=1.
  - RUN → IDLE when `i_enable`=0. Counters and trace keep their values.
  - RUN → HALTED on the HALT_REPEAT-th consecutive retirement with `i_pc` equal to the previously retired PC.
  - RUN → TIMEOUT when the idle-cycle counter reaches TIMEOUT.
  - HALTED and TIMEOUT leave only on `i_clear` or reset.
- Counting in RUN only:
  - `o_cycles` increments every cycle.
  - `o_retired` increments on each `i_insn_vld`.
  - Both counters saturate at all-ones.
- Halt detection:
  - The repeat counter loads 1 on a retirement at a new PC and increments on a retirement at the same PC.
  - Cycles with no retirement do not reset the repeat counter.
- Timeout: the idle counter resets on every retirement and increments otherwise.
- Trace:
  - Each retirement in RUN writes {pc, wb} at the write pointer; the pointer wraps modulo TRACE_DEPTH.
  - The fill count saturates at TRACE_DEPTH.
  - The retirement that triggers HALTED is counted and traced.
  - Nothing is counted or traced in IDLE, HALTED or TIMEOUT.
- Simultaneous events:
  - `i_clear` overrides everything else in the same cycle; a retirement in that cycle is dropped.
  - If the halt and timeout conditions occur in the same cycle, HALTED wins.
- Reset mid-operation is identical to `i_clear`.

## Timing
- Reset values: all outputs 0, state IDLE, trace fill count 0.
- Counters, flags and `o_state` update one cycle after the qualifying event (registered outputs).
- `o_halted` rises together with `o_state`=2, in the cycle after the triggering commit.
- Trace read is registered, with 1-cycle latency from `i_rd_idx`.
  - A write and a read of index 0 in the same cycle return the previous newest entry; the new entry is visible from the next read.
- `o_rd_vld`=1 iff `i_rd_idx` < fill count (sampled with the read).

## Configuration
- `RETIRE_MON_TRACE_EN`:
  - Defined: the trace buffer and read port are built.
  - Undefined: no storage is built; `o_rd_pc`, `o_rd_wb` and `o_rd_vld` are tied to 0; counters, FSM and flags are unchanged.

## Structure
- Shared package `retire_mon_pkg`:
  - `mon_state_e` enum (IDLE, RUN, HALTED, TIMEOUT)
  - `trace_entry_t` struct {pc, wb}
- One sub-module, `retire_trace_buf`: circular buffer with write pointer, fill count and registered newest-relative read.

## Test plan
- Reset check: hold `i_rst_n`=0 for 3 cycles with `i_insn_vld` toggling → all outputs 0, state IDLE. Then enable and retire 0x0, 0x4, 0x8 → `o_retired`=3, `o_cycles` counts RUN cycles.
- Halt detection:
  - Retire 0x10, then 0x14 four times with idle gaps between commits → `o_halted`=1 and state HALTED in the cycle after the 4th commit; `o_retired`=5.
  - Further commits → counters frozen.
- Timeout, TIMEOUT=8: enable, retire once, then no commits → state TIMEOUT after exactly 8 idle cycles.
  - `i_clear` → state IDLE, counters 0.
- Trace wrap, TRACE_DEPTH=4: retire PCs 0x0..0x18 (7 commits) → idx0=0x18, idx3=0xC, all `o_rd_vld`=1.
  - After `i_clear`, idx0 `o_rd_vld`=0.
- Simultaneous events: `i_clear` and `i_insn_vld` in the same cycle → retirement dropped, `o_retired`=0.
  - `i_enable` deasserted mid-run → counters hold, state IDLE.
- Build without `RETIRE_MON_TRACE_EN`: rerun the halt scenario → identical counters and flags, `o_rd_*` constantly 0.
